// File: rtl/up_counter_pkg.sv
// up_counter_pkg: shared constants for the up_counter family
package up_counter_pkg;
  localparam int unsigned DEFAULT_WIDTH = 4;
endpackage

// File: rtl/up_counter_count_incr.sv
// count_incr: combinational increment with all-ones detect for counters
module count_incr #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_inc,
  output logic             all_ones
);
  assign value_inc = value + 1'b1;
  assign all_ones  = &value;
endmodule

// File: rtl/up_counter.sv
// up_counter: wrapping WIDTH-bit up-counter with enable and terminal-count strobe
module up_counter
  import up_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] counter,
  output logic             tc
);
  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;
  logic [WIDTH-1:0] counter_inc;
  logic             all_ones;
  count_incr #(.WIDTH(WIDTH)) u_incr (
    .value    (counter_q),
    .value_inc(counter_inc),
    .all_ones (all_ones)
  );
  // next count and wrap strobe; tc is gated by rst so it drops while reset is held
  always_comb begin
    counter_d = en ? counter_inc : counter_q;
    tc        = en & all_ones & rst;
  end
  // count register, cleared asynchronously on reset assertion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) counter_q <= '0;
    else      counter_q <= counter_d;
  end
  assign counter = counter_q;
endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: directed self-checking bench for up_counter at WIDTH 4, 1 and 8
module tb_up_counter;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] c4;
  logic [0:0] c1;
  logic [7:0] c8;
  logic       tc4, tc1, tc8;
  int         n_checks = 0;
  int         n_fail = 0;
  int         tc8_pulses;

  always #5 clk = ~clk;

  up_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .en(en), .counter(c4), .tc(tc4));
  up_counter #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .en(en), .counter(c1), .tc(tc1));
  up_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .en(en), .counter(c8), .tc(tc8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    #1;
    check("reset_init", 32'(c4), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_hold_cnt", 32'(c4), 0);
      check("reset_hold_tc", 32'(tc4), 0);
    end
    en = 1'b1;
    #1;
    check("reset_tc_gated", 32'(tc4), 0);
    rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("basic_cnt", 32'(c4), 32'(i % 16));
      check("basic_tc", 32'(tc4), 32'((i % 16) == 15));
    end
    tick();
    tick();
    check("gate_reach6", 32'(c4), 6);
    en = 1'b0;
    #1;
    check("gate_tc_low", 32'(tc4), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_hold", 32'(c4), 6);
    end
    en = 1'b1;
    tick();
    check("gate_resume7", 32'(c4), 7);
    tick();
    check("gate_resume8", 32'(c4), 8);
    tick();
    check("async_at9", 32'(c4), 9);
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", 32'(c4), 0);
    check("async_tc", 32'(tc4), 0);
    tick();
    check("async_edge_ignored", 32'(c4), 0);
    rst = 1'b1;
    tick();
    check("release_first", 32'(c4), 1);
    for (int i = 0; i < 14; i++) tick();
    check("wrap_at15", 32'(c4), 15);
    check("wrap_tc_en1", 32'(tc4), 1);
    en = 1'b0;
    #1;
    check("wrap_tc_en0", 32'(tc4), 0);
    tick();
    check("wrap_hold15", 32'(c4), 15);
    check("wrap_hold_tc", 32'(tc4), 0);
    en = 1'b1;
    #1;
    check("wrap_tc_raise", 32'(tc4), 1);
    tick();
    check("wrap_to0", 32'(c4), 0);
    check("wrap_tc_after", 32'(tc4), 0);
    rst = 1'b0;
    #1;
    check("sweep_clear1", 32'(c1), 0);
    check("sweep_clear8", 32'(c8), 0);
    rst = 1'b1;
    tc8_pulses = 0;
    for (int i = 1; i <= 260; i++) begin
      tick();
      check("w1_cnt", 32'(c1), 32'(i % 2));
      check("w1_tc", 32'(tc1), 32'((i % 2) == 1));
      check("w8_cnt", 32'(c8), 32'(i % 256));
      check("w8_tc", 32'(tc8), 32'((i % 256) == 255));
      if (tc8) tc8_pulses++;
    end
    check("w8_tc_pulses", 32'(tc8_pulses), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
